// File: rtl/rf_multiport_pkg.sv
// Shared definitions for the multiport register file: clear-engine state
// encodings and the byte-lane helper used to size write enables.
package rf_multiport_pkg;

  // Clear engine states: S_CLEAR wipes the array after reset, S_READY is normal use.
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } clr_state_e;

  // Number of byte lanes in a data word (DATA_W is a multiple of 8).
  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/rf_multiport_clear_ctrl.sv
// Sequential clear engine: after reset it walks every entry once, issuing a
// zero write per cycle, then parks in S_READY until the next reset.
module rf_clear_ctrl
  import rf_multiport_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  // State and pointer registers; reset (also mid-clear) restarts the sweep at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: clear one entry per cycle, exit after the last entry so the pointer never wraps.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    if (state_q == S_CLEAR) begin
      clr_we = 1'b1;
      if (clr_ptr_q == '1) begin
        state_d = S_READY;
      end else begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      end
    end
  end

  assign clr_addr  = clr_ptr_q;
  assign init_busy = (state_q == S_CLEAR);

endmodule

// File: rtl/rf_multiport.sv
// Parametrised register file: NRD combinational read ports with optional
// write->read bypass, one byte-maskable write port, one debug read port and
// an optional hardwired-zero entry 0. Storage is cleared after reset by
// rf_clear_ctrl sharing the single write port, so no reset reaches the array.
module rf_multiport
  import rf_multiport_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic                  init_busy,
  output logic                  wr_drop,
  input  logic [ADDR_W-1:0]     dbg_sel,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BYTES = bytes_of(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              wp_we;
  logic [ADDR_W-1:0] wp_addr;
  logic [BYTES-1:0]  wp_be;
  logic [DATA_W-1:0] wp_data;

  logic              wr_to_zero;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] wr_merge_src;

  rf_clear_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .init_busy(init_busy)
  );

  assign wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);

  // Single write port: the clear engine owns it while busy, else the user port.
  always_comb begin
    wp_we   = wr_en && !wr_to_zero;
    wp_addr = wr_addr;
    wp_be   = wr_be;
    wp_data = wr_data;
    if (init_busy) begin
      wp_we   = clr_we;
      wp_addr = clr_addr;
      wp_be   = '1;
      wp_data = '0;
    end
  end

  // Array update with per-byte enables; untouched bytes keep their value.
  always_ff @(posedge clk) begin
    if (wp_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wp_be[b]) begin
          mem[wp_addr][b*8 +: 8] <= wp_data[b*8 +: 8];
        end
      end
    end
  end

  // Flag a user write that arrived while the clear engine was running.
  assign wr_drop_d = init_busy && wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
    end
  end

  assign wr_drop      = wr_drop_q;
  assign wr_merge_src = wr_data;

  // One read mux per port, each with its own bypass comparator.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] arr_word;
    logic [DATA_W-1:0] merged;
    logic              hit;

    assign ra       = rd_addr[gi*ADDR_W +: ADDR_W];
    assign arr_word = mem[ra];
    assign hit      = (BYPASS != 0) && wr_en && (wr_addr == ra);

    // Byte-merge of the in-flight write over the stored word for bypass.
    always_comb begin
      merged = arr_word;
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be[b]) begin
          merged[b*8 +: 8] = wr_merge_src[b*8 +: 8];
        end
      end
    end

    // Busy and the zero entry force 0, which also keeps bypass off both cases.
    assign rd_data[gi*DATA_W +: DATA_W] =
        (init_busy || ((ZERO_REG != 0) && (ra == '0))) ? '0 :
        (hit ? merged : arr_word);
  end

  // Debug port follows read-port rules but always shows the stored value.
  assign dbg_data = (init_busy || ((ZERO_REG != 0) && (dbg_sel == '0))) ? '0 : mem[dbg_sel];

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: instance A uses default parameters (bypass, zero
// entry), instance B uses NRD=3, DATA_W=64, ADDR_W=4 with no bypass and no
// zero entry. Expected values are queued when stimulus is applied and popped
// when the outputs are sampled.
module tb_rf_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [3:0]  a_wr_be;
  logic [31:0] a_wr_data;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic        a_init_busy;
  logic        a_wr_drop;
  logic [4:0]  a_dbg_sel;
  logic [31:0] a_dbg_data;

  // Instance B
  logic         b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [7:0]   b_wr_be;
  logic [63:0]  b_wr_data;
  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic         b_init_busy;
  logic         b_wr_drop;
  logic [3:0]   b_dbg_sel;
  logic [63:0]  b_dbg_data;

  rf_multiport u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (a_wr_en),
    .wr_addr  (a_wr_addr),
    .wr_be    (a_wr_be),
    .wr_data  (a_wr_data),
    .rd_addr  (a_rd_addr),
    .rd_data  (a_rd_data),
    .init_busy(a_init_busy),
    .wr_drop  (a_wr_drop),
    .dbg_sel  (a_dbg_sel),
    .dbg_data (a_dbg_data)
  );

  rf_multiport #(
    .DATA_W  (64),
    .ADDR_W  (4),
    .NRD     (3),
    .ZERO_REG(0),
    .BYPASS  (0)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (b_wr_en),
    .wr_addr  (b_wr_addr),
    .wr_be    (b_wr_be),
    .wr_data  (b_wr_data),
    .rd_addr  (b_rd_addr),
    .rd_data  (b_rd_data),
    .init_busy(b_init_busy),
    .wr_drop  (b_wr_drop),
    .dbg_sel  (b_dbg_sel),
    .dbg_data (b_dbg_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] model_a [32];
  logic [63:0] model_b [16];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [63:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, got, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts negedge samples with init_busy high, bounded so a stuck engine cannot hang the run.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (a_init_busy === 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
  endtask

  function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] merge64(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Instance A read expectation: zero entry, then bypass of the current write, then storage.
  function automatic logic [31:0] exp_a_rd(input logic [4:0] ad);
    if (ad == 5'd0) return 32'd0;
    if (a_wr_en && a_wr_addr == ad) return merge32(model_a[ad], a_wr_data, a_wr_be);
    return model_a[ad];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [4:0] ra0, ra1;
    logic [3:0] rb [3];

    rst = 1'b0;
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_be = '0; a_wr_data = '0;
    a_rd_addr = '0; a_dbg_sel = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_be = '0; b_wr_data = '0;
    b_rd_addr = '0; b_dbg_sel = '0;
    @(negedge clk);

    // 1: one-cycle reset pulse, clear duration and all-zero contents
    rst = 1'b1;
    sb_push("t1_busy_in_rst", 64'd1);
    sb_push("t1_drop_rst", 64'd0);
    step();
    sb_pop(64'(a_init_busy));
    sb_pop(64'(a_wr_drop));
    rst = 1'b0;
    a_rd_addr = {5'd4, 5'd3};
    a_dbg_sel = 5'd3;
    sb_push("t1_rd0_busy", 64'd0);
    sb_push("t1_dbg_busy", 64'd0);
    #1;
    sb_pop(64'(a_rd_data[31:0]));
    sb_pop(64'(a_dbg_data));
    sb_push("t1_busy_len", 64'd32);
    count_busy(cnt);
    sb_pop(64'(cnt));
    $display("[t1] reset pulse, init_busy lasted %0d cycles", cnt);
    for (int i = 0; i < 32; i++) begin
      a_rd_addr = {5'(31 - i), 5'(i)};
      a_dbg_sel = 5'(i);
      sb_push("t1_zero_rd0", 64'd0);
      sb_push("t1_zero_rd1", 64'd0);
      sb_push("t1_zero_dbg", 64'd0);
      #1;
      sb_pop(64'(a_rd_data[31:0]));
      sb_pop(64'(a_rd_data[63:32]));
      sb_pop(64'(a_dbg_data));
      step();
    end
    for (int i = 0; i < 16; i++) begin
      b_dbg_sel = 4'(i);
      sb_push("t1_b_zero_dbg", 64'd0);
      #1;
      sb_pop(b_dbg_data);
      step();
    end

    // 2: full write then partial byte write, plus a be=0 no-op
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_be = 4'hF; a_wr_data = 32'hDEADBEEF;
    step();
    a_wr_en = 1'b0;
    a_rd_addr = {5'd0, 5'd5};
    sb_push("t2_full", 64'hDEADBEEF);
    #1;
    sb_pop(64'(a_rd_data[31:0]));
    $display("[t2] write r5=0xdeadbeef be=f");
    a_wr_en = 1'b1; a_wr_be = 4'b0010; a_wr_data = 32'h0000AA00;
    sb_push("t2_byp_partial", 64'hDEADAAEF);
    #1;
    sb_pop(64'(a_rd_data[31:0]));
    step();
    a_wr_en = 1'b0;
    a_dbg_sel = 5'd5;
    sb_push("t2_partial", 64'hDEADAAEF);
    sb_push("t2_partial_dbg", 64'hDEADAAEF);
    #1;
    sb_pop(64'(a_rd_data[31:0]));
    sb_pop(64'(a_dbg_data));
    $display("[t2] write r5 be=2 data=0x0000aa00");
    a_wr_en = 1'b1; a_wr_be = 4'b0000; a_wr_data = 32'h0;
    step();
    a_wr_en = 1'b0;
    sb_push("t2_be0_noop", 64'hDEADAAEF);
    #1;
    sb_pop(64'(a_rd_data[31:0]));
    $display("[t2] write r5 be=0 (no-op)");

    // 3: same-cycle bypass on A (both ports), none on B
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_be = 4'hF; a_wr_data = 32'h12345678;
    a_rd_addr = {5'd7, 5'd7};
    a_dbg_sel = 5'd7;
    b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_be = 8'hFF; b_wr_data = 64'h1122334455667788;
    b_rd_addr = {4'd0, 4'd0, 4'd7};
    sb_push("t3_byp_rd0", 64'h12345678);
    sb_push("t3_byp_rd1", 64'h12345678);
    sb_push("t3_dbg_nobyp", 64'd0);
    sb_push("t3_b_old", 64'd0);
    #1;
    sb_pop(64'(a_rd_data[31:0]));
    sb_pop(64'(a_rd_data[63:32]));
    sb_pop(64'(a_dbg_data));
    sb_pop(b_rd_data[63:0]);
    step();
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
    sb_push("t3_after_rd0", 64'h12345678);
    sb_push("t3_after_rd1", 64'h12345678);
    sb_push("t3_b_new", 64'h1122334455667788);
    #1;
    sb_pop(64'(a_rd_data[31:0]));
    sb_pop(64'(a_rd_data[63:32]));
    sb_pop(b_rd_data[63:0]);
    $display("[t3] write r7=0x12345678 with both ports on r7");

    // 4: writes to the zero entry are discarded silently
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_be = 4'hF; a_wr_data = 32'hFFFFFFFF;
    a_rd_addr = {5'd7, 5'd0};
    sb_push("t4_r0_byp", 64'd0);
    #1;
    sb_pop(64'(a_rd_data[31:0]));
    step();
    a_wr_en = 1'b0;
    a_dbg_sel = 5'd0;
    sb_push("t4_r0_rd", 64'd0);
    sb_push("t4_r0_dbg", 64'd0);
    sb_push("t4_wr_drop", 64'd0);
    #1;
    sb_pop(64'(a_rd_data[31:0]));
    sb_pop(64'(a_dbg_data));
    sb_pop(64'(a_wr_drop));
    $display("[t4] write r0=0xffffffff");

    // 5: write during clear is dropped; reset mid-clear restarts the sweep
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) step();
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_be = 4'hF; a_wr_data = 32'h00000055;
    step();
    a_wr_en = 1'b0;
    sb_push("t5_drop_set", 64'd1);
    sb_push("t5_busy_mid", 64'd1);
    sb_pop(64'(a_wr_drop));
    sb_pop(64'(a_init_busy));
    step();
    sb_push("t5_drop_clr", 64'd0);
    sb_pop(64'(a_wr_drop));
    $display("[t5] write r9 during clear cycle 10");
    for (int c = 12; c < 20; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_push("t5_busy_len", 64'd32);
    count_busy(cnt);
    sb_pop(64'(cnt));
    $display("[t5] reset at clear cycle 20, init_busy lasted %0d cycles", cnt);
    a_rd_addr = {5'd5, 5'd9};
    a_dbg_sel = 5'd7;
    sb_push("t5_r9_lost", 64'd0);
    sb_push("t5_r5_clr", 64'd0);
    sb_push("t5_r7_clr", 64'd0);
    #1;
    sb_pop(64'(a_rd_data[31:0]));
    sb_pop(64'(a_rd_data[63:32]));
    sb_pop(64'(a_dbg_data));
    step();

    // 6: random traffic on both instances against reference models
    for (int i = 0; i < 32; i++) model_a[i] = '0;
    for (int i = 0; i < 16; i++) model_b[i] = '0;
    for (int n = 0; n < 10000; n++) begin
      a_wr_en   = 1'($urandom_range(0, 1));
      a_wr_addr = 5'($urandom_range(0, 31));
      a_wr_be   = 4'($urandom);
      a_wr_data = $urandom;
      ra0 = 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? a_wr_addr : 5'($urandom_range(0, 31));
      a_rd_addr = {ra1, ra0};
      a_dbg_sel = 5'($urandom_range(0, 31));
      b_wr_en   = 1'($urandom_range(0, 1));
      b_wr_addr = 4'($urandom_range(0, 15));
      b_wr_be   = 8'($urandom);
      b_wr_data = {$urandom, $urandom};
      for (int k = 0; k < 3; k++) rb[k] = 4'($urandom_range(0, 15));
      b_rd_addr = {rb[2], rb[1], rb[0]};
      b_dbg_sel = 4'($urandom_range(0, 15));

      sb_push("rnd_a_rd0", 64'(exp_a_rd(ra0)));
      sb_push("rnd_a_rd1", 64'(exp_a_rd(ra1)));
      sb_push("rnd_a_dbg", 64'((a_dbg_sel == 5'd0) ? 32'd0 : model_a[a_dbg_sel]));
      for (int k = 0; k < 3; k++) sb_push("rnd_b_rd", model_b[rb[k]]);
      sb_push("rnd_b_dbg", model_b[b_dbg_sel]);
      #1;
      sb_pop(64'(a_rd_data[31:0]));
      sb_pop(64'(a_rd_data[63:32]));
      sb_pop(64'(a_dbg_data));
      for (int k = 0; k < 3; k++) sb_pop(b_rd_data[k*64 +: 64]);
      sb_pop(b_dbg_data);
      $display("[t6] cyc %0d a:we=%0d r%0d be=%h d=%h  b:we=%0d r%0d be=%h d=%h",
               n, a_wr_en, a_wr_addr, a_wr_be, a_wr_data,
               b_wr_en, b_wr_addr, b_wr_be, b_wr_data);

      if (a_wr_en && a_wr_addr != 5'd0)
        model_a[a_wr_addr] = merge32(model_a[a_wr_addr], a_wr_data, a_wr_be);
      if (b_wr_en)
        model_b[b_wr_addr] = merge64(model_b[b_wr_addr], b_wr_data, b_wr_be);
      step();
    end
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
    sb_push("rnd_a_wr_drop", 64'd0);
    #1;
    sb_pop(64'(a_wr_drop));

    check_val("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
